// File: rtl/memory_controller.sv
// Memory controller between the CPU memory port and a synchronous 2^17 x 32 RAM.
// Handles reads, full-word writes and byte-lane partial writes via read-modify-write.
module memory_controller #(
  parameter int READ_LATENCY = 1
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [15:31]  cpu_addr,
  input  logic [0:31]   cpu_wdata,
  input  logic [0:3]    cpu_byte_en,
  output logic          cpu_ack,
  output logic [0:31]   cpu_rdata,
  output logic          busy,
  output logic          mem_en,
  output logic          mem_we,
  output logic [15:31]  mem_addr,
  output logic [0:31]   mem_wdata,
  input  logic [0:31]   mem_rdata
);

  typedef enum logic [2:0] {
    IDLE,
    READ_WAIT,
    RMW_WAIT,
    RMW_WRITE,
    DONE
  } state_t;

  localparam logic [2:0] LAT = 3'(READ_LATENCY);

  state_t       state;
  logic [15:31] addr;
  logic [0:31]  wdata;
  logic [0:3]   byte_en;
  logic         we;
  logic [2:0]   count;
  logic [0:31]  merged;

  // Byte lane i covers bits [8i:8i+7]; enabled lanes take the latched write data.
  always_comb begin
    merged = mem_rdata;
    for (int i = 0; i < 4; i++) begin
      if (byte_en[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      addr      <= '0;
      wdata     <= '0;
      byte_en   <= '0;
      we        <= 1'b0;
      count     <= '0;
      cpu_ack   <= 1'b0;
      cpu_rdata <= '0;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      cpu_ack <= 1'b0;
      mem_en  <= 1'b0;
      mem_we  <= 1'b0;
      case (state)
        IDLE: begin
          if (cpu_req) begin
            addr     <= cpu_addr;
            wdata    <= cpu_wdata;
            byte_en  <= cpu_byte_en;
            we       <= cpu_we;
            count    <= '0;
            busy     <= 1'b1;
            mem_en   <= 1'b1;
            mem_addr <= cpu_addr;
            if (cpu_we && cpu_byte_en == 4'b1111) begin
              mem_we    <= 1'b1;
              mem_wdata <= cpu_wdata;
              state     <= DONE;
            end else if (cpu_we && cpu_byte_en != 4'b0000) begin
              state <= RMW_WAIT;
            end else begin
              // An empty-mask write becomes a dummy read that never touches cpu_rdata.
              state <= READ_WAIT;
            end
          end
        end
        READ_WAIT: begin
          if (count == LAT) begin
            if (!we) cpu_rdata <= mem_rdata;
            cpu_ack <= 1'b1;
            busy    <= 1'b0;
            state   <= IDLE;
          end else begin
            count <= count + 3'd1;
          end
        end
        RMW_WAIT: begin
          if (count == LAT) begin
            mem_en    <= 1'b1;
            mem_we    <= 1'b1;
            mem_addr  <= addr;
            mem_wdata <= merged;
            state     <= RMW_WRITE;
          end else begin
            count <= count + 3'd1;
          end
        end
        RMW_WRITE, DONE: begin
          cpu_ack <= 1'b1;
          busy    <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/memory_controller.md
Name: memory_controller

Overview:
- Sits directly downstream of the microcoded CPU, between its word-addressed memory port and a synchronous 2^17 x 32 RAM.
- Accepts one CPU transaction at a time over a req/ack handshake: read, full-word write, or byte-lane partial write.
- Partial writes are performed as an internal read-modify-write.
- Sequences the RAM's fixed read latency and returns read data to the CPU's memory_data_in path.

Parameters:
- READ_LATENCY, 1, RAM clock edges from the edge that samples mem_en to mem_rdata valid (legal 1..4).

Ports:
- clock  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-low reset (0 = reset asserted)
- cpu_req  input  1  transaction request, held by CPU until cpu_ack
- cpu_we  input  1  1 = write, 0 = read
- cpu_addr  input  [15:31]  word address
- cpu_wdata  input  [0:31]  write data
- cpu_byte_en  input  [0:3]  byte lanes; bit 0 = bits [0:7] ... bit 3 = bits [24:31]; ignored on reads
- cpu_ack  output  1  one-cycle completion pulse
- cpu_rdata  output  [0:31]  read data, valid from the cpu_ack cycle and held until the next read completes
- busy  output  1  high whenever state is not IDLE
- mem_en  output  1  RAM access strobe
- mem_we  output  1  RAM write strobe (qualified by mem_en)
- mem_addr  output  [15:31]  RAM address
- mem_wdata  output  [0:31]  RAM write data
- mem_rdata  input  [0:31]  RAM read data

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; cpu_ack, busy, mem_en, mem_we=0; mem_addr, mem_wdata, cpu_rdata, and latched address/data/byte_en=0; latency counter=0.
- All outputs are registered; no combinational path from cpu_* to mem_*.
- States:
  - IDLE
  - READ_WAIT
  - RMW_WAIT
  - RMW_WRITE
  - DONE
- IDLE, at edge T with cpu_req=1: latch addr, wdata, byte_en, we. Then:
  - Read, or write with byte_en=4'b0000 routed as a read with no write phase: mem_en=1, mem_we=0, mem_addr=addr; go to READ_WAIT.
  - Write with byte_en=4'b1111: mem_en=1, mem_we=1, mem_wdata=wdata; go to DONE.
  - Write with any other non-zero mask: mem_en=1, mem_we=0; go to RMW_WAIT.
  - A byte_en=0000 write performs a dummy read, returns ack, and does not update cpu_rdata.
- mem_en and mem_we are high for exactly one cycle per RAM access.
- READ_WAIT: count READ_LATENCY edges after the issue edge. At edge T+1+READ_LATENCY capture mem_rdata into cpu_rdata, pulse cpu_ack, return to IDLE. Read latency from request edge to ack edge = 1+READ_LATENCY.
- RMW_WAIT: same count. At edge T+1+READ_LATENCY form merged = mem_rdata with each enabled lane replaced by the latched wdata lane. Drive mem_en=1, mem_we=1, mem_wdata=merged; go to RMW_WRITE. cpu_rdata is not updated.
- RMW_WRITE, and DONE after a full write: next edge pulses cpu_ack and returns to IDLE.
  - Full-write ack edge = T+1.
  - Partial-write ack edge = T+2+READ_LATENCY.
- cpu_ack is high only in the cycle after its edge. IDLE samples cpu_req again at the edge that ends the ack cycle. A CPU that still holds req then starts a new transaction; the CPU must drop req in the ack cycle.
- cpu_req and its inputs are ignored while busy=1. Latched values are used, so input changes mid-transaction have no effect.
- busy=1 from the accept edge until the edge that raises cpu_ack. busy=0 in the ack cycle.
- Reset mid-transaction aborts immediately: no ack, and mem_en/mem_we drop asynchronously. A partially completed RMW leaves RAM either unchanged or fully written, never partially merged in one word, because the write is a single strobe.
- Address wrap: none; 17-bit address is passed through unmodified, 0x1FFFF legal.

Test Plan:
- Reset low mid-READ_WAIT, READ_LATENCY=2 -> cpu_ack, busy, mem_en 0 immediately; after release, IDLE accepts new req on first edge.
- Read addr 0x00010, RAM holds 0xDEADBEEF, READ_LATENCY=1 -> mem_en one cycle with mem_addr=0x00010; cpu_ack at request edge+2, cpu_rdata=0xDEADBEEF, busy high for exactly 2 cycles.
- Full write addr 0x1FFFF data 0x12345678 byte_en=1111 -> single mem_en&mem_we cycle, mem_wdata=0x12345678; ack at edge+1; readback returns 0x12345678.
- Partial write byte_en=0101 data 0xAABBCCDD over RAM 0x11223344, READ_LATENCY=3 -> one read strobe, then write strobe with 0x11BB33DD; ack at edge+5; cpu_rdata unchanged.
- Write byte_en=0000 -> read strobe only, no mem_we, ack at edge+1+READ_LATENCY, RAM unchanged. Separately, cpu_req held high across ack -> second transaction accepted on the edge ending the ack cycle; no ack lost or duplicated.
- Toggle cpu_addr and cpu_wdata every cycle during READ_WAIT -> mem_addr and the returned data reflect only the values latched at accept.
